red_ctrl: RTL

- Multi-cycle sequencer for the reduced RISC-V datapath (register file, ALU source mux, ALU).
- Owns the program counter and instruction register, and fetches from a synchronous instruction ROM.
- Decodes addi/add/beq/bne, drives rs1/rs2/rd, ImmOp, ALUsrc, ALUctrl and RegWrite into the datapath.
- Consumes the datapath EQ flag to resolve branches. Fixed 3 cycles per instruction: FETCH, DECODE, EXEC.

---
 rtl/red_ctrl_pkg.sv | 48 ++++
 rtl/red_imm_gen.sv | 24 ++
 rtl/red_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/red_ctrl_pkg.sv
// Shared constants, state enum and instruction decode helper for red_ctrl.
// Covers opcode/funct3 values, ALU encodings and the legality decoder.
package red_ctrl_pkg;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {
      FETCH,
      DECODE,
      EXEC,
      HALT
   } ctrl_state_t;

   typedef struct packed {
      logic addi;
      logic add;
      logic beq;
      logic bne;
   } dec_t;

   // b1 is IR[8], i.e. bit 1 of the branch offset (misaligned target).
   function automatic dec_t decode(
      input logic [6:0] opc,
      input logic [2:0] f3,
      input logic [6:0] f7,
      input logic       b1
   );
      dec_t d;
      d.addi = (opc == OP_IMM) && (f3 == F3_ADD);
      d.add  = (opc == OP_REG) && (f3 == F3_ADD)
               && (f7 == 7'b0);
      d.beq  = (opc == OP_BRANCH) && (f3 == F3_BEQ) && !b1;
      d.bne  = (opc == OP_BRANCH) && (f3 == F3_BNE) && !b1;
      return d;
   endfunction

endpackage

// File: rtl/red_imm_gen.sv
// Immediate generator: I-type or B-type immediate, sign-extended.
// Ports: ir (instruction register) in, imm (extended immediate) out.
module red_imm_gen
   import red_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] ir,
   output logic [DATA_WIDTH-1:0] imm
);

   // rs1/funct3 bits take no part in any immediate format here.
   logic unused_ir;
   assign unused_ir = ^ir[19:12];

   always_comb begin
      imm = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
      if (ir[6:0] == OP_BRANCH) begin
         imm = {{(DATA_WIDTH-12){ir[31]}}, ir[7],
                ir[30:25], ir[11:8], 1'b0};
      end
   end

endmodule

// File: rtl/red_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the reduced RISC-V datapath.
// Ports: clk/rst_n/en, ROM addr/data, EQ flag, datapath controls, pc, retire, halted.
module red_ctrl
   import red_ctrl_pkg::*;
#(
   parameter int ADDRESS_WIDTH   = 5,
   parameter int ALUctrl_WIDTH   = 3,
   parameter int DATA_WIDTH      = 32,
   parameter int IMEM_ADDR_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   output logic [IMEM_ADDR_WIDTH-1:0] instr_addr,
   input  logic [DATA_WIDTH-1:0]      instr_rdata,
   input  logic                       EQ,
   output logic [ADDRESS_WIDTH-1:0]   rs1,
   output logic [ADDRESS_WIDTH-1:0]   rs2,
   output logic [ADDRESS_WIDTH-1:0]   rd,
   output logic [DATA_WIDTH-1:0]      ImmOp,
   output logic                       ALUsrc,
   output logic [ALUctrl_WIDTH-1:0]   ALUctrl,
   output logic                       RegWrite,
   output logic [DATA_WIDTH-1:0]      pc,
   output logic                       retire,
   output logic                       halted
);

   ctrl_state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] ir;
   logic [DATA_WIDTH-1:0] imm;
   logic [DATA_WIDTH-1:0] pc_nxt;
   dec_t fd;
   dec_t xd;
   logic taken;
   logic is_br;

   // fd judges legality of the word arriving from ROM during DECODE;
   // xd drives the datapath from the latched IR.
   assign fd = decode(instr_rdata[6:0], instr_rdata[14:12],
                      instr_rdata[31:25], instr_rdata[8]);
   assign xd = decode(ir[6:0], ir[14:12], ir[31:25], ir[8]);

   red_imm_gen #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_imm (
      .ir (ir),
      .imm(imm)
   );

   assign instr_addr = pc[IMEM_ADDR_WIDTH-1:0];
   assign rs1        = ir[15 +: ADDRESS_WIDTH];
   assign rs2        = ir[20 +: ADDRESS_WIDTH];
   assign rd         = ir[7  +: ADDRESS_WIDTH];
   assign ImmOp      = imm;

   assign is_br   = xd.beq | xd.bne;
   assign ALUsrc  = !(xd.add | is_br);
   assign ALUctrl = is_br ? ALUctrl_WIDTH'(ALU_SUB)
                          : ALUctrl_WIDTH'(ALU_ADD);

   assign taken  = (xd.beq & EQ) | (xd.bne & ~EQ);
   assign pc_nxt = taken ? pc + imm
                         : pc + DATA_WIDTH'(4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      RegWrite  = 1'b0;
      retire    = 1'b0;
      halted    = 1'b0;
      unique case (state)
         FETCH: begin
            if (en) state_nxt = DECODE;
         end
         DECODE: begin
            if (fd.addi | fd.add | fd.beq | fd.bne)
               state_nxt = EXEC;
            else
               state_nxt = HALT;
         end
         EXEC: begin
            RegWrite  = (xd.addi | xd.add) && (rd != '0);
            retire    = 1'b1;
            state_nxt = FETCH;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
         ir <= DATA_WIDTH'(NOP_INSTR);
      end else begin
         if (state == DECODE) ir <= instr_rdata;
         if (state == EXEC)   pc <= pc_nxt;
      end
   end

endmodule
